// File: rtl/usb_data_fifo_arbiter.sv
// usb_data_fifo_arbiter
//
// Shares the single USB data FIFO write port between two source FIFOs.
// src0 is the S-curve data FIFO. src1 is the second acquisition data FIFO.
//
// Grants alternate round-robin and are limited to BURST_MAX words, so a
// source that streams continuously cannot starve the other one. Every word
// read from a source passes through a one-word holding register. While the
// USB FIFO is full, that register keeps its word, so no word is ever lost
// or written twice.
//
// Optional feature, macro USB_ARB_HEADER_EN:
//   Each burst is preceded by a tag word, 16'hFA00 | source_id.
//
// Ports:
//   Clk                   system clock, rising edge
//   reset_n               asynchronous active-low reset
//   arb_enable            while low, no new grant is issued
//   src0_fifo_empty       src0 FIFO empty flag
//   src0_fifo_rd_en       src0 FIFO read strobe
//   src0_fifo_dout        src0 read data, valid 1 cycle after rd_en
//   src1_fifo_empty       src1 FIFO empty flag
//   src1_fifo_rd_en       src1 FIFO read strobe
//   src1_fifo_dout        src1 read data, valid 1 cycle after rd_en
//   usb_data_fifo_full    USB FIFO full flag
//   usb_data_fifo_wr_en   USB FIFO write strobe
//   usb_data_fifo_wr_din  USB FIFO write data
//   grant                 one-hot current owner, {src1, src0}
//   arb_busy              high whenever the arbiter is not idle
module usb_data_fifo_arbiter #(
    parameter int BURST_MAX = 16,
    parameter int DATA_W    = 16
) (
    input  logic              Clk,
    input  logic              reset_n,
    input  logic              arb_enable,
    input  logic              src0_fifo_empty,
    output logic              src0_fifo_rd_en,
    input  logic [DATA_W-1:0] src0_fifo_dout,
    input  logic              src1_fifo_empty,
    output logic              src1_fifo_rd_en,
    input  logic [DATA_W-1:0] src1_fifo_dout,
    input  logic              usb_data_fifo_full,
    output logic              usb_data_fifo_wr_en,
    output logic [DATA_W-1:0] usb_data_fifo_wr_din,
    output logic [1:0]        grant,
    output logic              arb_busy
);

    typedef enum logic [1:0] {
        IDLE,
`ifdef USB_ARB_HEADER_EN
        HDR,
`endif
        BURST,
        DRAIN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        grant_q;
    logic              last_grant;     // 1 = src1 owned the previous burst
    logic [7:0]        count;
    logic              hold_valid;
    logic [DATA_W-1:0] hold_data;
    logic              rd_pending;

    logic              grant_set;
    logic              pick_src1;
    logic              drain_done;
`ifdef USB_ARB_HEADER_EN
    logic              hdr_load;
    localparam logic [DATA_W-1:0] TAG_BASE = DATA_W'(16'hFA00);
`endif

    logic              sel_empty;
    logic [DATA_W-1:0] sel_dout;
    logic              hold_free;
    logic              capture;
    logic [8:0]        words_claimed;
    logic              rd_ok;

    // The source FIFO keeps dout stable until its next read. A read that is
    // still in flight can therefore wait in the source until the holding
    // register frees up. A new read is issued only in a cycle where the
    // in-flight word is captured. words_claimed also counts the in-flight
    // word, so the burst never reads more than BURST_MAX words.
    assign sel_empty     = grant_q[1] ? src1_fifo_empty : src0_fifo_empty;
    assign sel_dout      = grant_q[1] ? src1_fifo_dout  : src0_fifo_dout;
    assign hold_free     = !hold_valid || usb_data_fifo_wr_en;
    assign capture       = rd_pending && hold_free;
    assign words_claimed = {1'b0, count} + {8'd0, rd_pending};
    assign rd_ok         = (state == BURST) && !sel_empty && hold_free &&
                           (words_claimed < 9'(BURST_MAX));

    assign src0_fifo_rd_en      = rd_ok && grant_q[0];
    assign src1_fifo_rd_en      = rd_ok && grant_q[1];
    assign usb_data_fifo_wr_en  = hold_valid && !usb_data_fifo_full;
    assign usb_data_fifo_wr_din = hold_data;
    assign grant                = grant_q;
    assign arb_busy             = (state != IDLE);

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // When both sources are non-empty, the source that did not own the
    // previous burst wins. The burst ends at BURST_MAX captured words, when
    // the source runs dry with nothing in flight, or when arb_enable drops.
    // DRAIN lets any in-flight word and the held word reach the USB FIFO
    // before the grant is released.
    always_comb begin
        state_next = state;
        grant_set  = 1'b0;
        pick_src1  = 1'b0;
        drain_done = 1'b0;
`ifdef USB_ARB_HEADER_EN
        hdr_load   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (arb_enable && (!src0_fifo_empty || !src1_fifo_empty)) begin
                    grant_set = 1'b1;
                    pick_src1 = (!src0_fifo_empty && !src1_fifo_empty) ?
                                !last_grant : src0_fifo_empty;
`ifdef USB_ARB_HEADER_EN
                    state_next = HDR;
`else
                    state_next = BURST;
`endif
                end
            end
`ifdef USB_ARB_HEADER_EN
            HDR: begin
                hdr_load   = 1'b1;
                state_next = BURST;
            end
`endif
            BURST: begin
                if ((count == 8'(BURST_MAX)) || (sel_empty && !rd_pending) ||
                    !arb_enable) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!hold_valid && !rd_pending) begin
                    drain_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Grant, burst count and holding register. A capture in the same cycle
    // as a USB write reloads the register, so hold_valid stays set.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q    <= 2'b00;
            last_grant <= 1'b1;
            count      <= 8'd0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            rd_pending <= 1'b0;
        end else begin
            if (grant_set) begin
                grant_q <= pick_src1 ? 2'b10 : 2'b01;
            end else if (drain_done) begin
                grant_q    <= 2'b00;
                last_grant <= grant_q[1];
            end

            if (drain_done) begin
                count <= 8'd0;
            end else if (capture) begin
                count <= count + 8'd1;
            end

            rd_pending <= rd_ok || (rd_pending && !capture);

            if (capture) begin
                hold_valid <= 1'b1;
                hold_data  <= sel_dout;
            end
`ifdef USB_ARB_HEADER_EN
            else if (hdr_load) begin
                hold_valid <= 1'b1;
                hold_data  <= TAG_BASE | DATA_W'(grant_q[1]);
            end
`endif
            else if (usb_data_fifo_wr_en) begin
                hold_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_usb_data_fifo_arbiter.sv
// tb_usb_data_fifo_arbiter
//
// Self-checking bench for usb_data_fifo_arbiter.
//
// Both source FIFOs are modelled as queues with a one-cycle read latency.
// src0 words count up from 16'h0001 and src1 words count up from 16'h8001,
// so bit 15 of a word names its source. When the sources are loaded, a
// round-robin burst model pushes the expected USB write order into a
// scoreboard queue. A monitor pops that queue on every USB write.
// Build with USB_ARB_HEADER_EN defined to exercise the burst tag words.
`timescale 1ns/1ps
module tb_usb_data_fifo_arbiter;

    localparam int BURST_MAX = 16;
    localparam int DATA_W    = 16;

    logic              Clk = 1'b0;
    logic              reset_n;
    logic              arb_enable;
    logic              src0_fifo_empty;
    logic              src0_fifo_rd_en;
    logic [DATA_W-1:0] src0_fifo_dout;
    logic              src1_fifo_empty;
    logic              src1_fifo_rd_en;
    logic [DATA_W-1:0] src1_fifo_dout;
    logic              usb_data_fifo_full;
    logic              usb_data_fifo_wr_en;
    logic [DATA_W-1:0] usb_data_fifo_wr_din;
    logic [1:0]        grant;
    logic              arb_busy;

    int assertions = 0;
    int failures   = 0;

    logic [15:0] fifo0[$];
    logic [15:0] fifo1[$];
    logic [15:0] exp_q[$];
    logic [15:0] wr_log[$];
    int          data_writes;
    int          rd_run;
    int          max_rd_run;

    typedef struct {
        int         n0;
        int         n1;
        logic [1:0] first_grant;
        int         max_run;
    } vec_t;

    vec_t vecs[7];

    usb_data_fifo_arbiter #(
        .BURST_MAX(BURST_MAX),
        .DATA_W   (DATA_W)
    ) dut (
        .Clk                 (Clk),
        .reset_n             (reset_n),
        .arb_enable          (arb_enable),
        .src0_fifo_empty     (src0_fifo_empty),
        .src0_fifo_rd_en     (src0_fifo_rd_en),
        .src0_fifo_dout      (src0_fifo_dout),
        .src1_fifo_empty     (src1_fifo_empty),
        .src1_fifo_rd_en     (src1_fifo_rd_en),
        .src1_fifo_dout      (src1_fifo_dout),
        .usb_data_fifo_full  (usb_data_fifo_full),
        .usb_data_fifo_wr_en (usb_data_fifo_wr_en),
        .usb_data_fifo_wr_din(usb_data_fifo_wr_din),
        .grant               (grant),
        .arb_busy            (arb_busy)
    );

    always #5 Clk = ~Clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Source FIFO models. dout updates one cycle after rd_en, and the empty
    // flag reflects the queue contents after the pop.
    always @(posedge Clk) begin
        if (src0_fifo_rd_en) begin
            if (fifo0.size() == 0) begin
                assertions++;
                failures++;
                $display("[TB] FAIL rd0_nonempty: src0 read while its FIFO is empty");
            end else begin
                src0_fifo_dout <= fifo0.pop_front();
            end
            src0_fifo_empty <= (fifo0.size() == 0);
        end
        if (src1_fifo_rd_en) begin
            if (fifo1.size() == 0) begin
                assertions++;
                failures++;
                $display("[TB] FAIL rd1_nonempty: src1 read while its FIFO is empty");
            end else begin
                src1_fifo_dout <= fifo1.pop_front();
            end
            src1_fifo_empty <= (fifo1.size() == 0);
        end
    end

    // Monitor: tracks read runs, logs writes and pops the scoreboard.
    always @(negedge Clk) begin
        if (reset_n) begin
            if (src0_fifo_rd_en && src1_fifo_rd_en)
                check_output("rd_exclusive", 32'd1, 32'd0);
            if (src0_fifo_rd_en || src1_fifo_rd_en) begin
                rd_run++;
                if (rd_run > max_rd_run) max_rd_run = rd_run;
            end else begin
                rd_run = 0;
            end
            if (usb_data_fifo_wr_en) begin
                wr_log.push_back(usb_data_fifo_wr_din);
`ifdef USB_ARB_HEADER_EN
                if (usb_data_fifo_wr_din[15:8] == 8'hFA) begin
                    if (exp_q.size() == 0)
                        check_output("tag_expected", 32'd0, 32'd1);
                    else
                        check_output("tag_word", 32'(usb_data_fifo_wr_din),
                                     32'({8'hFA, 7'd0, exp_q[0][15]}));
                end else
`endif
                begin
                    data_writes++;
                    if (exp_q.size() == 0)
                        check_output("unexpected_write", 32'(usb_data_fifo_wr_din), 32'hFFFF_FFFF);
                    else
                        check_output("data_word", 32'(usb_data_fifo_wr_din), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Reference model of the write order. Sources alternate when both have
    // data, src0 wins first, and each burst takes at most BURST_MAX words.
    task automatic push_expected(input int n0, input int n1);
        int r0 = n0;
        int r1 = n1;
        int i0 = 0;
        int i1 = 0;
        int last = 1;
        int pick;
        int take;
        while (r0 > 0 || r1 > 0) begin
            if (r0 > 0 && r1 > 0) pick = 1 - last;
            else                  pick = (r0 > 0) ? 0 : 1;
            take = (pick == 0) ? r0 : r1;
            if (take > BURST_MAX) take = BURST_MAX;
            for (int k = 0; k < take; k++) begin
                if (pick == 0) begin
                    exp_q.push_back(16'h0001 + 16'(i0));
                    i0++;
                end else begin
                    exp_q.push_back(16'h8001 + 16'(i1));
                    i1++;
                end
            end
            if (pick == 0) r0 -= take;
            else           r1 -= take;
            last = pick;
        end
    endtask

    task automatic apply_stimulus(input int n0, input int n1);
        for (int k = 0; k < n0; k++) fifo0.push_back(16'h0001 + 16'(k));
        for (int k = 0; k < n1; k++) fifo1.push_back(16'h8001 + 16'(k));
        src0_fifo_empty = (fifo0.size() == 0);
        src1_fifo_empty = (fifo1.size() == 0);
    endtask

    task automatic clear_all();
        fifo0.delete();
        fifo1.delete();
        exp_q.delete();
        wr_log.delete();
        src0_fifo_empty = 1'b1;
        src1_fifo_empty = 1'b1;
        data_writes     = 0;
        rd_run          = 0;
        max_rd_run      = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_rd0"},   32'(src0_fifo_rd_en),      32'd0);
        check_output({tag, "_rd1"},   32'(src1_fifo_rd_en),      32'd0);
        check_output({tag, "_wr_en"}, 32'(usb_data_fifo_wr_en),  32'd0);
        check_output({tag, "_din"},   32'(usb_data_fifo_wr_din), 32'd0);
        check_output({tag, "_grant"}, 32'(grant),                32'd0);
        check_output({tag, "_busy"},  32'(arb_busy),             32'd0);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check_reset_outputs("reset");
        @(posedge Clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic wait_writes(input int n, input int limit, input string name);
        int c = 0;
        while (data_writes < n && c < limit) begin
            @(negedge Clk);
            c++;
        end
        check_output(name, 32'(data_writes >= n), 32'd1);
    endtask

    task automatic wait_done(input int limit, input string name);
        int  c = 0;
        logic done = 1'b0;
        while (!done && c < limit) begin
            @(negedge Clk);
            c++;
            done = (exp_q.size() == 0) && !arb_busy &&
                   (fifo0.size() == 0) && (fifo1.size() == 0);
        end
        check_output(name, 32'(done), 32'd1);
    endtask

    task automatic run_scenario(input vec_t v, input logic do_reset, input string name);
        logic       seen = 1'b0;
        logic [1:0] g = 2'b00;
        if (do_reset) apply_reset();
        clear_all();
        @(posedge Clk);
        #1;
        push_expected(v.n0, v.n1);
        apply_stimulus(v.n0, v.n1);
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge Clk);
            if (arb_busy) begin
                seen = 1'b1;
                g    = grant;
            end
        end
        if (v.first_grant == 2'b00)
            check_output({name, "_no_grant"}, 32'(seen), 32'd0);
        else
            check_output({name, "_first_grant"}, 32'(g), 32'(v.first_grant));
        wait_done(3000, {name, "_done"});
        check_output({name, "_word_count"}, 32'(data_writes), 32'(v.n0 + v.n1));
        check_output({name, "_max_rd_run"}, 32'(max_rd_run), 32'(v.max_run));
    endtask

    initial begin
        int          snap;
        int          bad_wr;
        int          bad_rd;
        logic        stayed;
        logic [15:0] exp_log[$];

        vecs[0] = '{5,  0,  2'b01, 5};
        vecs[1] = '{0,  3,  2'b10, 3};
        vecs[2] = '{40, 40, 2'b01, 16};
        vecs[3] = '{1,  1,  2'b01, 1};
        vecs[4] = '{20, 0,  2'b01, 16};
        vecs[5] = '{17, 2,  2'b01, 16};
        vecs[6] = '{0,  0,  2'b00, 0};

        reset_n            = 1'b0;
        arb_enable         = 1'b1;
        usb_data_fifo_full = 1'b0;
        src0_fifo_dout     = '0;
        src1_fifo_dout     = '0;
        clear_all();

        for (int i = 0; i < 7; i++) begin
            $display("[TB] table vector %0d: n0=%0d n1=%0d", i, vecs[i].n0, vecs[i].n1);
            run_scenario(vecs[i], 1'b1, $sformatf("vec%0d", i));
        end

        // USB FIFO full for 10 cycles in the middle of a burst.
        $display("[TB] back-pressure sequence");
        apply_reset();
        clear_all();
        @(posedge Clk);
        #1;
        push_expected(12, 0);
        apply_stimulus(12, 0);
        wait_writes(4, 60, "full_start");
        @(posedge Clk);
        #1 usb_data_fifo_full = 1'b1;
        snap   = data_writes;
        bad_wr = 0;
        bad_rd = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk);
            if (usb_data_fifo_wr_en) bad_wr++;
            if (c > 0 && src0_fifo_rd_en) bad_rd++;
        end
        check_output("full_no_wr_en", 32'(bad_wr), 32'd0);
        check_output("full_rd_stops", 32'(bad_rd), 32'd0);
        check_output("full_no_writes", 32'(data_writes), 32'(snap));
        @(posedge Clk);
        #1 usb_data_fifo_full = 1'b0;
        wait_done(500, "full_done");
        check_output("full_word_count", 32'(data_writes), 32'd12);

        // arb_enable drops on the 3rd word of a src1 burst.
        $display("[TB] arb_enable drop sequence");
        apply_reset();
        clear_all();
        @(posedge Clk);
        #1;
        push_expected(0, 10);
        apply_stimulus(0, 10);
        wait_writes(3, 60, "en_start");
        @(posedge Clk);
        #1 arb_enable = 1'b0;
        repeat (8) @(negedge Clk);
        check_output("en_grant_released", 32'(grant), 32'd0);
        check_output("en_idle", 32'(arb_busy), 32'd0);
        check_output("en_burst_cut", 32'(fifo1.size() > 0), 32'd1);
        stayed = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clk);
            if (arb_busy || grant != 2'b00 || src1_fifo_rd_en) stayed = 1'b0;
        end
        check_output("en_no_new_grant", 32'(stayed), 32'd1);
        @(posedge Clk);
        #1 arb_enable = 1'b1;
        wait_done(500, "en_done");
        check_output("en_word_count", 32'(data_writes), 32'd10);

        // Asynchronous reset in the middle of a burst, then a fresh tie.
        $display("[TB] mid-burst reset sequence");
        apply_reset();
        clear_all();
        @(posedge Clk);
        #1;
        push_expected(10, 10);
        apply_stimulus(10, 10);
        wait_writes(5, 60, "rst_start");
        @(negedge Clk);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        clear_all();
        @(posedge Clk);
        #1 reset_n = 1'b1;
        run_scenario('{3, 3, 2'b01, 3}, 1'b0, "after_reset");

        // Two src1 words with exact USB write sequence.
        $display("[TB] src1 two-word sequence");
        apply_reset();
        clear_all();
        @(posedge Clk);
        #1;
        fifo1.push_back(16'hBEEF);
        fifo1.push_back(16'h1234);
        exp_q.push_back(16'hBEEF);
        exp_q.push_back(16'h1234);
        src1_fifo_empty = 1'b0;
        wait_done(200, "seq_done");
`ifdef USB_ARB_HEADER_EN
        exp_log.push_back(16'hFA01);
`endif
        exp_log.push_back(16'hBEEF);
        exp_log.push_back(16'h1234);
        check_output("seq_length", 32'(wr_log.size()), 32'(exp_log.size()));
        for (int k = 0; k < exp_log.size(); k++) begin
            if (k < wr_log.size())
                check_output($sformatf("seq_word%0d", k), 32'(wr_log[k]), 32'(exp_log[k]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
